// File: rtl/cpu_axi_pkg.sv
// Shared AXI read-side definitions for the CPU memory interface.
package cpu_axi_pkg;

  // Read-path controller states.
  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_ADDR = 2'b01,
    S_DATA = 2'b11
  } rd_state_e;

  // Every beat is a full 32-bit word; bursts are incrementing.
  localparam logic [2:0] AXI_SIZE_4B    = 3'b010;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;

  // Round-robin pick between two requesters. A lone requester wins outright;
  // when both ask, the port that was not served last wins. The result is only
  // meaningful when at least one request is present.
  function automatic logic rr_pick(input logic req0, input logic req1,
                                   input logic last_grant);
    logic win;
    if (req0 && req1) win = ~last_grant;
    else              win = req1;
    return win;
  endfunction

endpackage

// File: rtl/axi_rd_arbiter.sv
// Two-port AXI4 read arbiter: the instruction page loader (port 0) and the
// data load unit (port 1) share one AR/R master. One burst in flight at a
// time; the R beats of that burst are steered back to the port that won it.
module axi_rd_arbiter
  import cpu_axi_pkg::*;
#(
  parameter int C_M_AXI_ADDR_WIDTH = 32,
  parameter int C_M_AXI_DATA_WIDTH = 32
) (
  input  logic                          CLK,
  input  logic                          RST,
  // port 0: instruction fetch page loader
  input  logic [C_M_AXI_ADDR_WIDTH-1:0] S0_ARADDR,
  input  logic [7:0]                    S0_ARLEN,
  input  logic                          S0_ARVALID,
  output logic                          S0_ARREADY,
  output logic [C_M_AXI_DATA_WIDTH-1:0] S0_RDATA,
  output logic [1:0]                    S0_RRESP,
  output logic                          S0_RLAST,
  output logic                          S0_RVALID,
  input  logic                          S0_RREADY,
  // port 1: data load unit
  input  logic [C_M_AXI_ADDR_WIDTH-1:0] S1_ARADDR,
  input  logic [7:0]                    S1_ARLEN,
  input  logic                          S1_ARVALID,
  output logic                          S1_ARREADY,
  output logic [C_M_AXI_DATA_WIDTH-1:0] S1_RDATA,
  output logic [1:0]                    S1_RRESP,
  output logic                          S1_RLAST,
  output logic                          S1_RVALID,
  input  logic                          S1_RREADY,
  // shared master towards the DRAM interconnect
  output logic [C_M_AXI_ADDR_WIDTH-1:0] M_AXI_ARADDR,
  output logic [7:0]                    M_AXI_ARLEN,
  output logic [2:0]                    M_AXI_ARSIZE,
  output logic [1:0]                    M_AXI_ARBURST,
  output logic                          M_AXI_ARVALID,
  input  logic                          M_AXI_ARREADY,
  input  logic [C_M_AXI_DATA_WIDTH-1:0] M_AXI_RDATA,
  input  logic [1:0]                    M_AXI_RRESP,
  input  logic                          M_AXI_RLAST,
  input  logic                          M_AXI_RVALID,
  output logic                          M_AXI_RREADY,
  // sticky: a burst ended on a beat count that disagreed with its ARLEN
  output logic                          ERR_RLAST
);

  rd_state_e                     state_q, state_d;
  logic                          owner_q;       // port that owns the burst in flight
  logic                          last_grant_q;  // port whose burst completed most recently
  logic [7:0]                    beat_cnt_q;    // beats accepted so far in this burst
  logic [C_M_AXI_ADDR_WIDTH-1:0] m_araddr_q;
  logic [7:0]                    m_arlen_q;     // doubles as the captured length for RLAST checking
  logic                          m_arvalid_q;
  logic                          err_q;

  logic any_req;
  logic grant;
  logic owner_rready;
  logic beat;

  assign any_req      = S0_ARVALID | S1_ARVALID;
  assign grant        = rr_pick(S0_ARVALID, S1_ARVALID, last_grant_q);
  assign owner_rready = owner_q ? S1_RREADY : S0_RREADY;
  // A beat only counts while the burst owner is actually connected to R.
  assign beat         = (state_q == S_DATA) && M_AXI_RVALID && owner_rready;

  assign M_AXI_ARADDR  = m_araddr_q;
  assign M_AXI_ARLEN   = m_arlen_q;
  assign M_AXI_ARSIZE  = AXI_SIZE_4B;
  assign M_AXI_ARBURST = AXI_BURST_INCR;
  assign M_AXI_ARVALID = m_arvalid_q;
  assign ERR_RLAST     = err_q;

  // R payload goes to the owner only; the idle port sees zeros. RRESP is
  // passed through unmodified, error responses are the requester's problem.
  assign S0_RDATA = owner_q ? '0 : M_AXI_RDATA;
  assign S0_RRESP = owner_q ? 2'b00 : M_AXI_RRESP;
  assign S0_RLAST = owner_q ? 1'b0 : M_AXI_RLAST;
  assign S1_RDATA = owner_q ? M_AXI_RDATA : '0;
  assign S1_RRESP = owner_q ? M_AXI_RRESP : 2'b00;
  assign S1_RLAST = owner_q ? M_AXI_RLAST : 1'b0;

  // Next-state decode plus the handshake strobes that depend on state.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    state_d      = state_q;
    S0_ARREADY   = 1'b0;
    S1_ARREADY   = 1'b0;
    S0_RVALID    = 1'b0;
    S1_RVALID    = 1'b0;
    M_AXI_RREADY = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        // Accept the winner in the same cycle it is seen.
        if (any_req) begin
          S0_ARREADY = ~grant;
          S1_ARREADY = grant;
          state_d    = S_ADDR;
        end
      end
      S_ADDR: begin
        if (M_AXI_ARREADY) state_d = S_DATA;
      end
      S_DATA: begin
        if (owner_q) begin
          S1_RVALID    = M_AXI_RVALID;
          M_AXI_RREADY = S1_RREADY;
        end else begin
          S0_RVALID    = M_AXI_RVALID;
          M_AXI_RREADY = S0_RREADY;
        end
        // Only the slave's RLAST ends the burst, even if the count disagrees.
        if (beat && M_AXI_RLAST) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge CLK or negedge RST) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!RST) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  // Request capture, AR handshake, beat counting and the sticky length check.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      owner_q      <= 1'b0;
      last_grant_q <= 1'b1;   // port 0 wins the first tie after reset
      beat_cnt_q   <= 8'd0;
      m_araddr_q   <= '0;
      m_arlen_q    <= 8'd0;
      m_arvalid_q  <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      if (state_q == S_IDLE && any_req) begin
        owner_q     <= grant;
        m_araddr_q  <= grant ? S1_ARADDR : S0_ARADDR;
        m_arlen_q   <= grant ? S1_ARLEN  : S0_ARLEN;
        m_arvalid_q <= 1'b1;
        beat_cnt_q  <= 8'd0;
      end
      if (state_q == S_ADDR && M_AXI_ARREADY) m_arvalid_q <= 1'b0;
      if (beat) begin
        beat_cnt_q <= beat_cnt_q + 8'd1;
        if (M_AXI_RLAST) last_grant_q <= owner_q;
        // RLAST must coincide exactly with the beat numbered ARLEN: early
        // RLAST and a missing RLAST on that beat are both flagged.
        if (M_AXI_RLAST != (beat_cnt_q == m_arlen_q)) err_q <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Self-checking bench for axi_rd_arbiter: directed scenarios plus a random
// phase, checked against a transaction-level model of the arbitration rules.
module tb_axi_rd_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;

  logic          CLK;
  logic          RST;
  logic [AW-1:0] S0_ARADDR, S1_ARADDR;
  logic [7:0]    S0_ARLEN, S1_ARLEN;
  logic          S0_ARVALID, S1_ARVALID, S0_ARREADY, S1_ARREADY;
  logic [DW-1:0] S0_RDATA, S1_RDATA;
  logic [1:0]    S0_RRESP, S1_RRESP;
  logic          S0_RLAST, S1_RLAST, S0_RVALID, S1_RVALID, S0_RREADY, S1_RREADY;
  logic [AW-1:0] M_AXI_ARADDR;
  logic [7:0]    M_AXI_ARLEN;
  logic [2:0]    M_AXI_ARSIZE;
  logic [1:0]    M_AXI_ARBURST;
  logic          M_AXI_ARVALID, M_AXI_ARREADY;
  logic [DW-1:0] M_AXI_RDATA;
  logic [1:0]    M_AXI_RRESP;
  logic          M_AXI_RLAST, M_AXI_RVALID, M_AXI_RREADY;
  logic          ERR_RLAST;

  axi_rd_arbiter #(.C_M_AXI_ADDR_WIDTH(AW), .C_M_AXI_DATA_WIDTH(DW)) dut (
    .CLK(CLK), .RST(RST),
    .S0_ARADDR(S0_ARADDR), .S0_ARLEN(S0_ARLEN), .S0_ARVALID(S0_ARVALID), .S0_ARREADY(S0_ARREADY),
    .S0_RDATA(S0_RDATA), .S0_RRESP(S0_RRESP), .S0_RLAST(S0_RLAST), .S0_RVALID(S0_RVALID),
    .S0_RREADY(S0_RREADY),
    .S1_ARADDR(S1_ARADDR), .S1_ARLEN(S1_ARLEN), .S1_ARVALID(S1_ARVALID), .S1_ARREADY(S1_ARREADY),
    .S1_RDATA(S1_RDATA), .S1_RRESP(S1_RRESP), .S1_RLAST(S1_RLAST), .S1_RVALID(S1_RVALID),
    .S1_RREADY(S1_RREADY),
    .M_AXI_ARADDR(M_AXI_ARADDR), .M_AXI_ARLEN(M_AXI_ARLEN), .M_AXI_ARSIZE(M_AXI_ARSIZE),
    .M_AXI_ARBURST(M_AXI_ARBURST), .M_AXI_ARVALID(M_AXI_ARVALID), .M_AXI_ARREADY(M_AXI_ARREADY),
    .M_AXI_RDATA(M_AXI_RDATA), .M_AXI_RRESP(M_AXI_RRESP), .M_AXI_RLAST(M_AXI_RLAST),
    .M_AXI_RVALID(M_AXI_RVALID), .M_AXI_RREADY(M_AXI_RREADY),
    .ERR_RLAST(ERR_RLAST)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- environment: requesters, slave, model ----------------
  bit          req_pend[2];
  logic [31:0] req_addr[2];
  logic [7:0]  req_len[2];
  int          req_more[2], req_gap[2];
  int          gap_max, len_max;
  bit          rready[2];
  int          stall_cnt[2];
  int          rr_stall_pct, ar_stall_pct, rv_stall_pct;
  int          stall_at_beat, stall_seen;
  // slave
  bit          sl_active, sl_rvalid, rand_len_err;
  int          sl_total, sl_idx, sl_override;
  logic [31:0] sl_data;
  logic [1:0]  sl_resp;
  // model: one burst outstanding, round-robin between the two ports
  bit          mdl_busy, mdl_arvalid, err_exp;
  int          mdl_owner, mdl_last;
  logic [31:0] mdl_addr;
  logic [7:0]  mdl_len;
  int          grant_log[$];
  int          bursts_done, beats_this;
  logic [31:0] sent_q[$], got_q[$];
  bit          hs_s[2];
  bit          hs_m, hs_r;

  task automatic drive();
    S0_ARVALID    = req_pend[0];
    S0_ARADDR     = req_addr[0];
    S0_ARLEN      = req_len[0];
    S1_ARVALID    = req_pend[1];
    S1_ARADDR     = req_addr[1];
    S1_ARLEN      = req_len[1];
    S0_RREADY     = rready[0];
    S1_RREADY     = rready[1];
    M_AXI_RVALID  = sl_rvalid;
    M_AXI_RDATA   = sl_data;
    M_AXI_RRESP   = sl_resp;
    M_AXI_RLAST   = sl_rvalid && (sl_idx == sl_total - 1);
  endtask

  task automatic clear_env();
    for (int n = 0; n < 2; n++) begin
      req_pend[n] = 1'b0; req_addr[n] = '0; req_len[n] = '0;
      req_more[n] = 0; req_gap[n] = 0; rready[n] = 1'b1; stall_cnt[n] = 0;
      hs_s[n] = 1'b0;
    end
    gap_max = 0; len_max = 7; rr_stall_pct = 0; ar_stall_pct = 0; rv_stall_pct = 0;
    stall_at_beat = -1; stall_seen = 0;
    sl_active = 1'b0; sl_rvalid = 1'b0; rand_len_err = 1'b0;
    sl_total = 0; sl_idx = 0; sl_override = 0; sl_data = '0; sl_resp = '0;
    mdl_busy = 1'b0; mdl_arvalid = 1'b0; err_exp = 1'b0; mdl_owner = 0; mdl_last = 1;
    mdl_addr = '0; mdl_len = '0; bursts_done = 0; beats_this = 0;
    hs_m = 1'b0; hs_r = 1'b0;
    grant_log.delete(); sent_q.delete(); got_q.delete();
    M_AXI_ARREADY = 1'b0;
    drive();
  endtask

  task automatic post_req(input int n, input logic [31:0] a, input logic [7:0] l);
    req_pend[n] = 1'b1; req_addr[n] = a; req_len[n] = l;
    drive();
  endtask

  // Negedge: compare the DUT against the model, then note the handshakes
  // that the coming rising edge will complete.
  task automatic sample();
    int          w;
    logic        own_rv, oth_rv;
    logic [31:0] own_d;
    logic [1:0]  own_resp;
    logic        own_last;
    @(negedge CLK);
    if (mdl_busy) check("arready_busy", {S1_ARREADY, S0_ARREADY}, 2'b00);
    else begin
      if (req_pend[0] && req_pend[1]) w = 1 - mdl_last;
      else if (req_pend[0])           w = 0;
      else if (req_pend[1])           w = 1;
      else                            w = -1;
      check("s0_arready", S0_ARREADY, w == 0);
      check("s1_arready", S1_ARREADY, w == 1);
    end
    check("m_arvalid", M_AXI_ARVALID, mdl_arvalid);
    if (mdl_arvalid) begin
      check("m_araddr", M_AXI_ARADDR, mdl_addr);
      check("m_arlen",  M_AXI_ARLEN,  mdl_len);
    end
    own_rv   = mdl_owner ? S1_RVALID : S0_RVALID;
    oth_rv   = mdl_owner ? S0_RVALID : S1_RVALID;
    own_d    = mdl_owner ? S1_RDATA  : S0_RDATA;
    own_resp = mdl_owner ? S1_RRESP  : S0_RRESP;
    own_last = mdl_owner ? S1_RLAST  : S0_RLAST;
    if (mdl_busy && !mdl_arvalid) begin
      check("own_rvalid", own_rv, M_AXI_RVALID);
      check("oth_rvalid", oth_rv, 1'b0);
      check("m_rready", M_AXI_RREADY, rready[mdl_owner]);
      if (M_AXI_RVALID) begin
        check("own_rdata", own_d,    sl_data);
        check("own_rresp", own_resp, sl_resp);
        check("own_rlast", own_last, sl_idx == sl_total - 1);
        if (!rready[mdl_owner]) stall_seen++;
      end
    end else begin
      check("idle_rvalid", {S1_RVALID, S0_RVALID}, 2'b00);
      check("idle_rready", M_AXI_RREADY, 1'b0);
    end
    if (!mdl_busy) check("err_rlast", ERR_RLAST, err_exp);
    hs_s[0] = S0_ARVALID && S0_ARREADY;
    hs_s[1] = S1_ARVALID && S1_ARREADY;
    hs_m    = M_AXI_ARVALID && M_AXI_ARREADY;
    hs_r    = M_AXI_RVALID && M_AXI_RREADY;
    if (own_rv && rready[mdl_owner]) got_q.push_back(own_d);
    if (hs_r) sent_q.push_back(M_AXI_RDATA);
  endtask

  // Just after the rising edge: advance the model and drive new stimulus.
  task automatic apply();
    bit last;
    @(posedge CLK);
    #1;
    if (hs_r) begin
      last = (sl_idx == sl_total - 1);
      sl_idx++; sl_rvalid = 1'b0; beats_this++;
      if (last) begin
        sl_active = 1'b0; mdl_busy = 1'b0; mdl_last = mdl_owner; bursts_done++;
        if (sl_total != int'(mdl_len) + 1) err_exp = 1'b1;
      end
    end
    for (int n = 0; n < 2; n++) if (hs_s[n]) begin
      req_pend[n] = 1'b0; mdl_busy = 1'b1; mdl_arvalid = 1'b1; mdl_owner = n;
      mdl_addr = req_addr[n]; mdl_len = req_len[n]; grant_log.push_back(n); beats_this = 0;
      req_gap[n] = (gap_max > 0) ? $urandom_range(0, gap_max) : 0;
    end
    if (hs_m) begin
      mdl_arvalid = 1'b0; sl_active = 1'b1; sl_idx = 0; sl_total = int'(mdl_len) + 1;
      if (sl_override > 0) begin
        sl_total = sl_override; sl_override = 0;
      end else if (rand_len_err && $urandom_range(0, 9) == 0) begin
        sl_total = (sl_total > 1 && $urandom_range(0, 1) == 1) ? sl_total - 1 : sl_total + 1;
      end
    end
    for (int n = 0; n < 2; n++) if (!req_pend[n] && req_more[n] > 0) begin
      if (req_gap[n] > 0) req_gap[n]--;
      else begin
        req_pend[n] = 1'b1; req_addr[n] = $urandom & 32'hFFFF_FFFC;
        req_len[n] = 8'($urandom_range(0, len_max)); req_more[n]--;
      end
    end
    if (sl_active && !sl_rvalid && $urandom_range(0, 99) >= rv_stall_pct) begin
      sl_rvalid = 1'b1; sl_data = $urandom; sl_resp = 2'($urandom_range(0, 3));
    end
    M_AXI_ARREADY = ($urandom_range(0, 99) >= ar_stall_pct);
    if (stall_at_beat >= 0 && mdl_busy && !mdl_arvalid && beats_this == stall_at_beat) begin
      stall_cnt[mdl_owner] = 3; stall_at_beat = -1;
    end
    for (int n = 0; n < 2; n++) begin
      if (stall_cnt[n] > 0) begin rready[n] = 1'b0; stall_cnt[n]--; end
      else rready[n] = ($urandom_range(0, 99) >= rr_stall_pct);
    end
    drive();
  endtask

  task automatic cycle();
    sample();
    apply();
  endtask

  task automatic run_bursts(input int target, input string tag);
    int b = 0;
    while (bursts_done < target && b < 4000) begin cycle(); b++; end
    check({tag, "_bursts"}, bursts_done, target);
  endtask

  task automatic check_stream(input string tag);
    int n;
    check({tag, "_beat_count"}, got_q.size(), sent_q.size());
    n = (got_q.size() < sent_q.size()) ? got_q.size() : sent_q.size();
    for (int i = 0; i < n; i++) check({tag, "_beat_data"}, got_q[i], sent_q[i]);
    got_q.delete(); sent_q.delete();
  endtask

  task automatic do_reset();
    RST = 1'b0;
    #1;
    check("rst_arvalid", M_AXI_ARVALID, 1'b0);
    check("rst_araddr",  M_AXI_ARADDR,  '0);
    check("rst_arlen",   M_AXI_ARLEN,   8'd0);
    check("rst_err",     ERR_RLAST,     1'b0);
    check("rst_rvalid",  {S1_RVALID, S0_RVALID}, 2'b00);
    check("rst_rready",  M_AXI_RREADY,  1'b0);
    clear_env();
    #1;
    check("rst_arready", {S1_ARREADY, S0_ARREADY}, 2'b00);
    repeat (2) @(posedge CLK);
    #1;
    RST = 1'b1;
  endtask

  initial begin
    int b;
    RST = 1'b1;
    clear_env();
    #2;
    do_reset();
    check("arsize",  M_AXI_ARSIZE,  3'b010);
    check("arburst", M_AXI_ARBURST, 2'b01);

    // Lone S0 request, 32-beat burst.
    ar_stall_pct = 20; rv_stall_pct = 10;
    post_req(0, 32'h2000_0000, 8'h1f);
    run_bursts(1, "t1");
    check("t1_grant_count", grant_log.size(), 1);
    if (grant_log.size() == 1) check("t1_grant", grant_log[0], 0);
    check("t1_beats", beats_this, 32);
    check_stream("t1");
    check("t1_err", ERR_RLAST, 1'b0);

    // Simultaneous requests right after reset: S0 first, then S1.
    do_reset();
    post_req(0, 32'h0000_1000, 8'd3);
    post_req(1, 32'h0000_2000, 8'd2);
    run_bursts(2, "t2");
    check("t2_grant_count", grant_log.size(), 2);
    if (grant_log.size() == 2) begin
      check("t2_first",  grant_log[0], 0);
      check("t2_second", grant_log[1], 1);
    end
    check_stream("t2");

    // Both ports keep requesting: grants alternate 0,1,0,1.
    grant_log.delete(); bursts_done = 0;
    gap_max = 0; len_max = 3; req_more[0] = 1; req_more[1] = 1;
    post_req(0, 32'h0000_3000, 8'd1);
    post_req(1, 32'h0000_4000, 8'd2);
    run_bursts(4, "t3");
    check("t3_grant_count", grant_log.size(), 4);
    if (grant_log.size() == 4)
      for (int i = 0; i < 4; i++) check("t3_alternate", grant_log[i], i % 2);
    check_stream("t3");

    // S0 back-pressures for 3 cycles mid-burst.
    bursts_done = 0; rv_stall_pct = 0; stall_seen = 0; stall_at_beat = 3;
    post_req(0, 32'h0000_5000, 8'd7);
    run_bursts(1, "t4");
    check("t4_stall_cycles", stall_seen, 3);
    check("t4_beats", beats_this, 8);
    check_stream("t4");

    // Slave ends a len-7 burst after 5 beats: sticky error, back to idle.
    bursts_done = 0; sl_override = 5;
    post_req(0, 32'h0000_6000, 8'd7);
    run_bursts(1, "t5");
    check("t5_beats", beats_this, 5);
    cycle();
    check("t5_err_set", ERR_RLAST, 1'b1);
    post_req(1, 32'h0000_7000, 8'd2);
    run_bursts(2, "t5b");
    cycle();
    check("t5_err_sticky", ERR_RLAST, 1'b1);
    check_stream("t5");

    // Reset during beat 10 of a 16-beat burst, then a clean S1 burst.
    bursts_done = 0;
    post_req(0, 32'h0000_8000, 8'd15);
    b = 0;
    while (!(mdl_busy && !mdl_arvalid && beats_this == 10) && b < 2000) begin cycle(); b++; end
    check("t6_reach_beat10", beats_this, 10);
    do_reset();
    post_req(1, 32'h0000_9000, 8'd3);
    run_bursts(1, "t6");
    check("t6_grant_count", grant_log.size(), 1);
    if (grant_log.size() == 1) check("t6_grant", grant_log[0], 1);
    check_stream("t6");
    cycle();
    check("t6_err", ERR_RLAST, 1'b0);

    // Random traffic with stalls and occasional wrong-length bursts.
    bursts_done = 0; ar_stall_pct = 30; rv_stall_pct = 30; rr_stall_pct = 30;
    gap_max = 3; len_max = 15; rand_len_err = 1'b1; req_more[0] = 6; req_more[1] = 6;
    run_bursts(12, "t7");
    check_stream("t7");
    cycle();
    check("t7_err", ERR_RLAST, err_exp);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
